// File: rtl/lsu_align_ctrl.sv
// Load/store alignment controller: splits word-crossing accesses into two word
// accesses, positions store lanes and merges/extends load data.
module lsu_align_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [2:0]  i_req_funct3,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_wmask,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata,
    output logic        o_resp_valid,
    output logic [31:0] o_resp_rdata,
    output logic        o_resp_err
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StAcc0 = 2'd1;
    localparam logic [1:0] StAcc1 = 2'd2;
    localparam logic [1:0] StResp = 2'd3;

    logic [1:0]    r_state;
    logic          r_we;
    logic [2:0]    r_funct3;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [31:0]   r_w0;
    logic [31:0]   r_rdata;
    logic          r_err;
    logic [CW-1:0] r_cnt;

    logic          w_in_legal;
    logic          w_acc0;
    logic          w_acc1;
    logic [1:0]    w_offset;
    logic [3:0]    w_size_mask;
    logic [7:0]    w_mask8;
    logic          w_cross;
    logic [63:0]   w_wdata64;
    logic [31:0]   w_base;
    logic [31:0]   w_lo;
    logic [31:0]   w_hi;
    logic [31:0]   w_merged;
    logic [31:0]   w_load;

    always_comb begin
        w_in_legal = 1'b0;
        case (i_req_funct3)
            3'b000, 3'b001, 3'b010: w_in_legal = 1'b1;
            3'b100, 3'b101:         w_in_legal = !i_req_we;
            default:                w_in_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_size_mask = 4'b1111;
        case (r_funct3[1:0])
            2'b00:   w_size_mask = 4'b0001;
            2'b01:   w_size_mask = 4'b0011;
            default: w_size_mask = 4'b1111;
        endcase
    end

    assign w_acc0    = (r_state == StAcc0);
    assign w_acc1    = (r_state == StAcc1);
    assign w_offset  = r_addr[1:0];
    assign w_base    = {r_addr[31:2], 2'b00};
    // Upper nibble of the shifted mask is the second word's lanes.
    assign w_mask8   = {4'b0000, w_size_mask} << w_offset;
    assign w_cross   = |w_mask8[7:4];
    assign w_wdata64 = {32'd0, r_wdata} << {w_offset, 3'b000};

    // In ACC0 the live read word is w0; in ACC1 it is w1 and w0 comes from r_w0.
    assign w_lo     = w_acc1 ? r_w0 : i_mem_rdata;
    assign w_hi     = w_acc1 ? i_mem_rdata : 32'd0;
    assign w_merged = 32'({w_hi, w_lo} >> {w_offset, 3'b000});

    always_comb begin
        w_load = w_merged;
        case (r_funct3)
            3'b000:  w_load = {{24{w_merged[7]}}, w_merged[7:0]};
            3'b001:  w_load = {{16{w_merged[15]}}, w_merged[15:0]};
            3'b100:  w_load = {24'd0, w_merged[7:0]};
            3'b101:  w_load = {16'd0, w_merged[15:0]};
            default: w_load = w_merged;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= StIdle;
            r_we     <= 1'b0;
            r_funct3 <= 3'b000;
            r_addr   <= 32'd0;
            r_wdata  <= 32'd0;
            r_w0     <= 32'd0;
            r_rdata  <= 32'd0;
            r_err    <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (i_req_valid) begin
                        r_we     <= i_req_we;
                        r_funct3 <= i_req_funct3;
                        r_addr   <= i_req_addr;
                        r_wdata  <= i_req_wdata;
                        r_w0     <= 32'd0;
                        r_rdata  <= 32'd0;
                        r_err    <= !w_in_legal;
                        r_cnt    <= '0;
                        r_state  <= w_in_legal ? StAcc0 : StResp;
                    end
                end
                StAcc0: begin
                    if (i_mem_ack) begin
                        r_w0  <= i_mem_rdata;
                        r_cnt <= '0;
                        if (w_cross) begin
                            r_state <= StAcc1;
                        end else begin
                            r_state <= StResp;
                            if (!r_we) r_rdata <= w_load;
                        end
                    end else if (r_cnt == CNT_LAST) begin
                        r_err   <= 1'b1;
                        r_rdata <= 32'd0;
                        r_state <= StResp;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                StAcc1: begin
                    if (i_mem_ack) begin
                        r_state <= StResp;
                        if (!r_we) r_rdata <= w_load;
                    end else if (r_cnt == CNT_LAST) begin
                        // An already-acked first store half stays committed.
                        r_err   <= 1'b1;
                        r_rdata <= 32'd0;
                        r_state <= StResp;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                StResp:  r_state <= StIdle;
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_req_ready  = (r_state == StIdle);
    assign o_mem_req    = w_acc0 | w_acc1;
    assign o_mem_we     = (w_acc0 | w_acc1) & r_we;
    assign o_mem_addr   = w_acc0 ? w_base : (w_acc1 ? w_base + 32'd4 : 32'd0);
    assign o_mem_wdata  = !r_we ? 32'd0 :
                          (w_acc0 ? w_wdata64[31:0] : (w_acc1 ? w_wdata64[63:32] : 32'd0));
    assign o_mem_wmask  = !r_we ? 4'b0000 :
                          (w_acc0 ? w_mask8[3:0] : (w_acc1 ? w_mask8[7:4] : 4'b0000));
    assign o_resp_valid = (r_state == StResp);
    assign o_resp_rdata = r_rdata;
    assign o_resp_err   = (r_state == StResp) & r_err;

endmodule

// File: tb/tb_lsu_align_ctrl.sv
// Self-checking bench for lsu_align_ctrl: byte-level memory model plus
// directed scenarios and randomized loads/stores with random wait states.
module tb_lsu_align_ctrl;

    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    lsu_align_ctrl #(.TIMEOUT(TO)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_we     (req_we),
        .i_req_funct3 (req_funct3),
        .i_req_addr   (req_addr),
        .i_req_wdata  (req_wdata),
        .o_mem_req    (mem_req),
        .o_mem_we     (mem_we),
        .o_mem_addr   (mem_addr),
        .o_mem_wdata  (mem_wdata),
        .o_mem_wmask  (mem_wmask),
        .i_mem_ack    (mem_ack),
        .i_mem_rdata  (mem_rdata),
        .o_resp_valid (resp_valid),
        .o_resp_rdata (resp_rdata),
        .o_resp_err   (resp_err)
    );

    // Byte-addressed memory; unwritten bytes read a fixed address hash.
    logic [7:0] mem [int unsigned];

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        logic [31:0] h;
        if (mem.exists(a)) return mem[a];
        h = a ^ (a >> 11) ^ (a >> 19);
        return h[7:0] ^ 8'h5a;
    endfunction

    function automatic void poke_word(input logic [31:0] a, input logic [31:0] w);
        for (int j = 0; j < 4; j++) mem[a + 32'(j)] = w[8*j +: 8];
    endfunction

    function automatic int size_of(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic is_legal(input logic we, input logic [2:0] f3);
        if (we) return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
        return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    endfunction

    // Load result straight from memory bytes at addr..addr+n-1 (wrapping).
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] v;
        v = 32'd0;
        for (int i = 0; i < size_of(f3); i++) v[8*i +: 8] = mem_byte(a + 32'(i));
        if (f3 == 3'b000) return {{24{v[7]}}, v[7:0]};
        if (f3 == 3'b001) return {{16{v[15]}}, v[15:0]};
        return v;
    endfunction

    // Memory responder: acks after ack_delay wait cycles, logs every acked access.
    int          ack_delay = 0;
    int          acks_left = -1;
    int          wait_cnt = 0;
    int          req_cycles = 0;
    bit          noise = 1'b0;
    logic [31:0] h_addr, h_wdata;
    logic [3:0]  h_mask;
    logic        h_we;
    logic [31:0] q_addr[$];
    logic [31:0] q_wdata[$];
    logic [3:0]  q_mask[$];
    logic        q_we[$];

    always @(negedge clk) begin
        if (mem_req === 1'b1) begin
            req_cycles++;
            if (wait_cnt > 0) begin
                vectors++;
                if ({mem_addr, mem_wdata, mem_wmask, mem_we} !== {h_addr, h_wdata, h_mask, h_we}) begin
                    miscompares++;
                    $display("FAIL hold_stable: got %h/%h/%b/%b want %h/%h/%b/%b", mem_addr,
                             mem_wdata, mem_wmask, mem_we, h_addr, h_wdata, h_mask, h_we);
                end
            end else begin
                h_addr = mem_addr; h_wdata = mem_wdata; h_mask = mem_wmask; h_we = mem_we;
            end
            if (ack_delay >= 0 && wait_cnt >= ack_delay && acks_left != 0) begin
                mem_ack = 1'b1;
                mem_rdata = {mem_byte(mem_addr + 32'd3), mem_byte(mem_addr + 32'd2),
                             mem_byte(mem_addr + 32'd1), mem_byte(mem_addr)};
                q_addr.push_back(mem_addr);
                q_wdata.push_back(mem_wdata);
                q_mask.push_back(mem_wmask);
                q_we.push_back(mem_we);
                if (mem_we === 1'b1) begin
                    for (int j = 0; j < 4; j++)
                        if (mem_wmask[j]) mem[mem_addr + 32'(j)] = mem_wdata[8*j +: 8];
                end
                if (acks_left > 0) acks_left--;
                wait_cnt = 0;
            end else begin
                mem_ack = 1'b0;
                mem_rdata = $urandom;
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
            mem_ack = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            mem_rdata = $urandom;
        end
    end

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output logic [31:0] rd, output logic er,
                         output int lat);
        q_addr.delete(); q_wdata.delete(); q_mask.delete(); q_we.delete();
        req_cycles = 0;
        @(negedge clk);
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_idle: got %b want 1", req_ready);
        end
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        lat = 1;
        while (resp_valid !== 1'b1 && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        rd = resp_rdata;
        er = resp_err;
        vectors++;
        if (req_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL ready_resp: got %b want 0", req_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        vectors++;
        if ({req_ready, mem_req, mem_we, resp_valid, resp_err, mem_wmask} !== 9'b1_0000_0000) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b want 100000000",
                     {req_ready, mem_req, mem_we, resp_valid, resp_err, mem_wmask});
        end
        vectors++;
        if ({mem_addr, mem_wdata, resp_rdata} !== 96'd0) begin
            miscompares++;
            $display("FAIL reset_data: got %h %h %h want 0", mem_addr, mem_wdata, resp_rdata);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if ({req_ready, mem_req, resp_valid} !== 3'b100) begin
            miscompares++;
            $display("FAIL idle_after_reset: got %b want 100", {req_ready, mem_req, resp_valid});
        end
    endtask

    task automatic test_lw_aligned();
        logic [31:0] rd; logic er; int lat;
        poke_word(32'h100, 32'hDEADBEEF);
        ack_delay = 0;
        issue(1'b0, 3'b010, 32'h100, 32'd0, rd, er, lat);
        vectors++;
        if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
            miscompares++; $display("FAIL lw_data: got %h err %b want deadbeef err 0", rd, er);
        end
        vectors++;
        if (lat != 2) begin miscompares++; $display("FAIL lw_latency: got %0d want 2", lat); end
        vectors++;
        if (q_addr.size() != 1 || q_addr[0] !== 32'h100 || q_mask[0] !== 4'b0000) begin
            miscompares++;
            $display("FAIL lw_access: got n=%0d want one access at 100 mask 0", q_addr.size());
        end
    endtask

    task automatic test_lb_lbu();
        logic [31:0] rd; logic er; int lat;
        poke_word(32'h100, 32'h80FF1234);
        issue(1'b0, 3'b000, 32'h103, 32'd0, rd, er, lat);
        vectors++;
        if (rd !== 32'hFFFFFF80) begin
            miscompares++; $display("FAIL lb_sign: got %h want ffffff80", rd);
        end
        issue(1'b0, 3'b100, 32'h103, 32'd0, rd, er, lat);
        vectors++;
        if (rd !== 32'h00000080) begin
            miscompares++; $display("FAIL lbu_zero: got %h want 00000080", rd);
        end
    endtask

    task automatic test_sw_cross();
        logic [31:0] rd; logic er; int lat;
        issue(1'b1, 3'b010, 32'h102, 32'hAABBCCDD, rd, er, lat);
        vectors++;
        if (lat != 3 || er !== 1'b0 || rd !== 32'd0) begin
            miscompares++; $display("FAIL sw_resp: got lat %0d err %b rd %h want 3 0 0", lat, er, rd);
        end
        vectors++;
        if (q_addr.size() != 2) begin
            miscompares++; $display("FAIL sw_count: got %0d want 2", q_addr.size());
        end else begin
            if ({q_addr[0], q_mask[0], q_wdata[0]} !== {32'h100, 4'b1100, 32'hCCDD0000}) begin
                miscompares++;
                $display("FAIL sw_first: got %h %b %h want 100 1100 ccdd0000",
                         q_addr[0], q_mask[0], q_wdata[0]);
            end
            vectors++;
            if ({q_addr[1], q_mask[1], q_wdata[1]} !== {32'h104, 4'b0011, 32'h0000AABB}) begin
                miscompares++;
                $display("FAIL sw_second: got %h %b %h want 104 0011 0000aabb",
                         q_addr[1], q_mask[1], q_wdata[1]);
            end
        end
    endtask

    task automatic test_lh_wrap();
        logic [31:0] rd; logic er; int lat;
        poke_word(32'hFFFFFFFC, 32'h11000000);
        poke_word(32'h00000000, 32'h000000F2);
        issue(1'b0, 3'b001, 32'hFFFFFFFF, 32'd0, rd, er, lat);
        vectors++;
        if (rd !== 32'hFFFFF211) begin
            miscompares++; $display("FAIL lh_wrap_data: got %h want fffff211", rd);
        end
        vectors++;
        if (q_addr.size() != 2 || q_addr[1] !== 32'h0) begin
            miscompares++; $display("FAIL lh_wrap_addr: got n=%0d want second access at 0",
                                    q_addr.size());
        end
    endtask

    task automatic test_illegal();
        logic [31:0] rd; logic er; int lat;
        issue(1'b0, 3'b011, 32'h200, 32'd0, rd, er, lat);
        vectors++;
        if ({er, rd} !== {1'b1, 32'd0} || lat != 1 || req_cycles != 0) begin
            miscompares++;
            $display("FAIL illegal: got err %b rd %h lat %0d reqs %0d want 1 0 1 0",
                     er, rd, lat, req_cycles);
        end
    endtask

    task automatic test_timeout();
        logic [31:0] rd; logic er; int lat;
        ack_delay = -1;
        issue(1'b0, 3'b010, 32'h400, 32'd0, rd, er, lat);
        vectors++;
        if ({er, rd} !== {1'b1, 32'd0}) begin
            miscompares++; $display("FAIL timeout_resp: got err %b rd %h want 1 0", er, rd);
        end
        vectors++;
        if (req_cycles != TO || lat != TO + 1) begin
            miscompares++;
            $display("FAIL timeout_len: got req %0d lat %0d want %0d %0d", req_cycles, lat, TO, TO + 1);
        end
        ack_delay = 0;
        acks_left = 1;
        issue(1'b1, 3'b010, 32'h4FE, 32'h12345678, rd, er, lat);
        acks_left = -1;
        vectors++;
        if ({er, rd} !== {1'b1, 32'd0} || lat != TO + 2 || req_cycles != TO + 1) begin
            miscompares++;
            $display("FAIL timeout_half: got err %b rd %h lat %0d req %0d", er, rd, lat, req_cycles);
        end
        vectors++;
        if ({mem_byte(32'h4FF), mem_byte(32'h4FE)} !== 16'h5678) begin
            miscompares++;
            $display("FAIL half_commit: got %h%h want 5678", mem_byte(32'h4FF), mem_byte(32'h4FE));
        end
    endtask

    task automatic test_back_to_back();
        logic [6:1] rv_exp;
        logic [6:1] rdy_exp;
        rv_exp = 6'b010010;
        rdy_exp = 6'b100100;
        poke_word(32'h300, 32'hCAFEF00D);
        ack_delay = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h300;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            vectors++;
            if ({resp_valid, req_ready} !== {rv_exp[c], rdy_exp[c]}) begin
                miscompares++;
                $display("FAIL b2b_c%0d: got valid %b ready %b want %b %b", c, resp_valid,
                         req_ready, rv_exp[c], rdy_exp[c]);
            end
            if (c == 5) begin
                vectors++;
                if (resp_rdata !== 32'hCAFEF00D) begin
                    miscompares++; $display("FAIL b2b_data: got %h want cafef00d", resp_rdata);
                end
            end
        end
        req_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mid_reset();
        ack_delay = 0;
        acks_left = 1;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b001; req_addr = 32'h203;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h204) begin
            miscompares++; $display("FAIL in_acc1: got req %b addr %h want 1 204", mem_req, mem_addr);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({mem_req, req_ready, resp_valid} !== 3'b010) begin
            miscompares++;
            $display("FAIL async_reset: got %b want 010", {mem_req, req_ready, resp_valid});
        end
        @(negedge clk);
        rst_n = 1'b1;
        acks_left = -1;
        @(negedge clk);
        vectors++;
        if ({mem_req, req_ready, resp_valid} !== 3'b010) begin
            miscompares++;
            $display("FAIL post_reset: got %b want 010", {mem_req, req_ready, resp_valid});
        end
    endtask

    task automatic test_random();
        logic [2:0]  ld_codes [5];
        logic        we, legal, er;
        logic [2:0]  f3;
        logic [31:0] addr, wd, rd, exp_rd, base;
        int          n, nacc, d, lat, exp_lat, pop;
        ld_codes = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        noise = 1'b1;
        acks_left = -1;
        for (int k = 0; k < 200; k++) begin
            we = 1'($urandom);
            if ($urandom_range(0, 9) == 0) f3 = 3'($urandom);
            else if (we) f3 = 3'($urandom_range(0, 2));
            else f3 = ld_codes[$urandom_range(0, 4)];
            if ($urandom_range(0, 3) == 0) addr = 32'hFFFFFFFC | 32'($urandom_range(0, 3));
            else addr = $urandom;
            wd = $urandom;
            d = $urandom_range(0, 3);
            ack_delay = d;
            legal = is_legal(we, f3);
            n = size_of(f3);
            nacc = !legal ? 0 : ((int'(addr[1:0]) + n > 4) ? 2 : 1);
            exp_lat = legal ? 1 + nacc * (d + 1) : 1;
            exp_rd = (legal && !we) ? ref_load(f3, addr) : 32'd0;
            base = {addr[31:2], 2'b00};
            issue(we, f3, addr, wd, rd, er, lat);
            vectors++;
            if (er !== !legal) begin
                miscompares++; $display("FAIL rnd_err[%0d]: got %b want %b", k, er, !legal);
            end
            vectors++;
            if (rd !== exp_rd) begin
                miscompares++;
                $display("FAIL rnd_rdata[%0d] f3=%0d addr=%h: got %h want %h", k, f3, addr, rd, exp_rd);
            end
            vectors++;
            if (lat != exp_lat) begin
                miscompares++; $display("FAIL rnd_lat[%0d]: got %0d want %0d", k, lat, exp_lat);
            end
            vectors++;
            if (q_addr.size() != nacc) begin
                miscompares++; $display("FAIL rnd_nacc[%0d]: got %0d want %0d", k, q_addr.size(), nacc);
            end
            if (nacc >= 1 && q_addr.size() >= 1) begin
                vectors++;
                if (q_addr[0] !== base) begin
                    miscompares++; $display("FAIL rnd_addr0[%0d]: got %h want %h", k, q_addr[0], base);
                end
            end
            if (nacc == 2 && q_addr.size() == 2) begin
                vectors++;
                if (q_addr[1] !== base + 32'd4) begin
                    miscompares++;
                    $display("FAIL rnd_addr1[%0d]: got %h want %h", k, q_addr[1], base + 32'd4);
                end
            end
            pop = 0;
            for (int i = 0; i < q_addr.size(); i++) begin
                pop += $countones(q_mask[i]);
                vectors++;
                if (q_we[i] !== we || (!we && q_mask[i] !== 4'b0000)) begin
                    miscompares++;
                    $display("FAIL rnd_kind[%0d]: got we %b mask %b want we %b", k, q_we[i],
                             q_mask[i], we);
                end
            end
            if (we && legal) begin
                vectors++;
                if (pop != n) begin
                    miscompares++; $display("FAIL rnd_lanes[%0d]: got %0d want %0d", k, pop, n);
                end
                for (int i = 0; i < n; i++) begin
                    vectors++;
                    if (mem_byte(addr + 32'(i)) !== wd[8*i +: 8]) begin
                        miscompares++;
                        $display("FAIL rnd_store[%0d] byte %0d: got %h want %h", k, i,
                                 mem_byte(addr + 32'(i)), wd[8*i +: 8]);
                    end
                end
            end
        end
        noise = 1'b0;
    endtask

    initial begin
        test_reset();
        test_lw_aligned();
        test_lb_lbu();
        test_sw_cross();
        test_lh_wrap();
        test_illegal();
        test_timeout();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
